// File: rtl/pi_pwm_driver.sv
// PWM output stage for the PI loop: saturates the signed control word into a
// shadowed duty count and drives complementary high/low outputs with dead time.
module pi_pwm_driver #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 10,
    parameter int PERIOD = 1000,
    parameter int DEAD   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     ctrl_valid,
    input  logic signed [CTRL_W-1:0] control,
    output logic                     pwm_h,
    output logic                     pwm_l,
    output logic                     period_start,
    output logic        [CNT_W-1:0]  duty_active,
    output logic                     sat_hi,
    output logic                     sat_lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DT_W = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

    localparam logic        [CNT_W-1:0]  PERIOD_C = CNT_W'(PERIOD);
    localparam logic        [CNT_W-1:0]  LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic signed [CTRL_W-1:0] PERIOD_S = CTRL_W'(PERIOD);
    localparam logic        [DT_W-1:0]   DEAD_C   = DT_W'(DEAD);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic               sat_hi_q, sat_hi_d;
    logic               sat_lo_q, sat_lo_d;
    logic               start_q, start_d;
    logic               raw_q, raw_d;
    logic [DT_W-1:0]    dt_q, dt_d;

    // Saturation: the flags travel with the pending duty and only change on a new sample.
    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pending_d = pending_q;
        sat_hi_d  = sat_hi_q;
        sat_lo_d  = sat_lo_q;
        if (ctrl_valid) begin
            if (control[CTRL_W-1]) begin
                pending_d = '0;
                sat_hi_d  = 1'b0;
                sat_lo_d  = 1'b1;
            end else if (control > PERIOD_S) begin
                pending_d = PERIOD_C;
                sat_hi_d  = 1'b1;
                sat_lo_d  = 1'b0;
            end else begin
                pending_d = control[CNT_W-1:0];
                sat_hi_d  = 1'b0;
                sat_lo_d  = 1'b0;
            end
        end
    end

    // Period sequencer; the shadow duty is only reloaded at a period boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                    duty_d  = pending_q;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    duty_d  = pending_q;
                    start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Modulator and dead-time counter; a transition during dead time restarts it.
    always_comb begin
        raw_d = (state_d == RUN) && (cnt_d < duty_d);
        if (state_d == IDLE) begin
            dt_d = '0;
        end else if (raw_d != raw_q) begin
            dt_d = DEAD_C;
        end else if (dt_q != '0) begin
            dt_d = dt_q - DT_W'(1);
        end else begin
            dt_d = dt_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            duty_q    <= '0;
            sat_hi_q  <= 1'b0;
            sat_lo_q  <= 1'b0;
            start_q   <= 1'b0;
            raw_q     <= 1'b0;
            dt_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            duty_q    <= duty_d;
            sat_hi_q  <= sat_hi_d;
            sat_lo_q  <= sat_lo_d;
            start_q   <= start_d;
            raw_q     <= raw_d;
            dt_q      <= dt_d;
        end
    end

    // Both drives are gated by the same dt==0 term, so they can never overlap.
    assign pwm_h        = raw_q  && (dt_q == '0) && (state_q == RUN);
    assign pwm_l        = !raw_q && (dt_q == '0) && (state_q == RUN);
    assign period_start = start_q;
    assign duty_active  = duty_q;
    assign sat_hi       = sat_hi_q;
    assign sat_lo       = sat_lo_q;

endmodule
